// File: rtl/irq_arbiter.sv
// Machine-mode interrupt arbiter: synchronises and masks interrupt sources, picks a fixed-priority
// winner and runs a req/ack/done handshake with the core trap logic; IE/IP/CAUSE via Wishbone.
module irq_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h20000C10,
  parameter int          NUM_FAST  = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  input  logic                mtip_i,
  input  logic                msip_i,
  input  logic                meip_i,
  input  logic [NUM_FAST-1:0] fast_irq_i,
  input  logic                global_en_i,
  input  logic                irq_ack_i,
  input  logic                irq_done_i,
  output logic                irq_req_o,
  output logic [4:0]          irq_cause_o,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  localparam logic [31:0] FAST_MASK = ((32'd1 << NUM_FAST) - 32'd1) << 16;
  localparam logic [31:0] IE_MASK   = 32'h0000_0888 | FAST_MASK;

  // Handshake: irq_req_o/irq_cause_o are registered and held stable while in REQ; the core
  // asserts irq_ack_i for one cycle to take the trap, then irq_done_i on mret (SERVICE -> IDLE).

  logic [31:0]         ie_q;
  logic                meip_s1, meip_s2;
  logic [NUM_FAST-1:0] fast_s1, fast_s2, fast_s3;
  logic [NUM_FAST-1:0] pend_q, fast_edge, pend_clr;
  logic [31:0]         ip, eligible;
  logic [4:0]          winner, cause_q;
  logic [1:0]          state_q;
  logic                req_q;
  logic                wb_acc, wb_wr, sel_ie, sel_ip, sel_cause;

  assign wb_acc    = wb_cyc_i & wb_stb_i;
  assign wb_wr     = wb_acc & wb_we_i;
  assign sel_ie    = (wb_adr_i == BASE_ADDR);
  assign sel_ip    = (wb_adr_i == BASE_ADDR + 32'd4);
  assign sel_cause = (wb_adr_i == BASE_ADDR + 32'd8);
  assign wb_ack_o  = wb_acc;

  always_comb begin
    wb_dat_o = '0;
    if (wb_acc && !wb_we_i) begin
      if (sel_ie)         wb_dat_o = ie_q;
      else if (sel_ip)    wb_dat_o = ip;
      else if (sel_cause) wb_dat_o = {27'b0, cause_q};
    end
  end

  always_comb begin
    ip     = '0;
    ip[3]  = msip_i;
    ip[7]  = mtip_i;
    ip[11] = meip_s2;
    for (int k = 0; k < NUM_FAST; k++) ip[16+k] = pend_q[k];
  end

  assign eligible  = ip & ie_q;
  assign fast_edge = fast_s2 & ~fast_s3;

  // Lowest fast index wins among fast IRQs, so scan downwards and let the last hit stand.
  always_comb begin
    winner = '0;
    if (eligible[11])     winner = 5'd11;
    else if (eligible[3]) winner = 5'd3;
    else if (eligible[7]) winner = 5'd7;
    else begin
      for (int k = NUM_FAST - 1; k >= 0; k--) begin
        if (eligible[16+k]) winner = 5'(16 + k);
      end
    end
  end

  always_comb begin
    pend_clr = '0;
    for (int k = 0; k < NUM_FAST; k++) begin
      pend_clr[k] = (wb_wr && sel_ip && wb_dat_i[16+k]) ||
                    (state_q == REQ && irq_ack_i && cause_q == 5'(16 + k));
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ie_q    <= '0;
      meip_s1 <= 1'b0;
      meip_s2 <= 1'b0;
      fast_s1 <= '0;
      fast_s2 <= '0;
      fast_s3 <= '0;
      pend_q  <= '0;
    end else begin
      if (wb_wr && sel_ie) ie_q <= wb_dat_i & IE_MASK;
      meip_s1 <= meip_i;
      meip_s2 <= meip_s1;
      fast_s1 <= fast_irq_i;
      fast_s2 <= fast_s1;
      fast_s3 <= fast_s2;
      // A new edge outranks a simultaneous clear so no event is lost.
      pend_q  <= (pend_q & ~pend_clr) | fast_edge;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      cause_q <= '0;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (global_en_i && (|eligible)) begin
            cause_q <= winner;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (irq_ack_i) begin
            req_q   <= 1'b0;
            state_q <= SERVICE;
          end else if (!global_en_i || !eligible[cause_q]) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        SERVICE: begin
          req_q <= 1'b0;
          if (irq_done_i) state_q <= IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign irq_req_o   = req_q;
  assign irq_cause_o = cause_q;
  assign dbg_state   = state_q;

endmodule
